uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_sync2.sv | 13 +
 rtl/uart_rx_cfg.sv | 100 ++++++++++
 tb/tb_uart_rx_cfg.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity selection and receiver state types
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for the asynchronous rx line, resets to idle-high
// ports: clk50m clock, rst_n async active-low reset, d raw input, q synchronised output
module uart_sync2 (
  input  logic clk50m,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk50m or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (WIDTH data bits, optional parity, 1 or 2 stop bits)
// ports: clk50m/rst_n clock and async active-low reset; rx serial line; rx_ack consumer accept;
//        rx_data/rx_valid received word; rx_idle receiver idle; rx_frame_err/rx_parity_err/rx_overrun sticky flags
module uart_rx_cfg import uart_pkg::*; #(
  parameter int      WIDTH     = 8,
  parameter int      FCLK      = 50000000,
  parameter int      FBAUD     = 115200,
  parameter parity_t PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             rx_ack,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_idle,
  output logic             rx_frame_err,
  output logic             rx_parity_err,
  output logic             rx_overrun
);
  localparam int DIV  = FCLK / FBAUD;
  localparam int HALF = DIV / 2;
  localparam int TW   = $clog2(DIV);
  localparam int CW   = $clog2(WIDTH);
  if (WIDTH < 5 || WIDTH > 9) begin : g_bad_width
    $error("uart_rx_cfg: WIDTH must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (DIV < 4) begin : g_bad_div
    $error("uart_rx_cfg: FCLK/FBAUD must be at least 4");
  end
  state_t           state;
  logic [TW-1:0]    tmr;
  logic [CW-1:0]    bcnt;
  logic [WIDTH-1:0] shreg;
  logic             rxs, rxs_d, perr, ferr, tick, fin, ack;
  uart_sync2 u_sync (.clk50m(clk50m), .rst_n(rst_n), .d(rx), .q(rxs));
  assign tick    = tmr == '0;
  // fin marks the final stop-bit sample; bcnt is reused as the stop-bit counter
  assign fin     = state == ST_STOP && tick && bcnt == CW'(STOP_BITS - 1);
  assign ack     = rx_ack && rx_valid;
  assign rx_idle = state == ST_IDLE;
  always_ff @(posedge clk50m or negedge rst_n)
    if (!rst_n) begin
      state         <= ST_IDLE;
      tmr           <= '0;
      bcnt          <= '0;
      shreg         <= '0;
      perr          <= 1'b0;
      ferr          <= 1'b0;
      rxs_d         <= 1'b1;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rxs_d         <= rxs;
      rx_data       <= fin ? shreg : rx_data;
      rx_valid      <= fin || (rx_valid && !rx_ack);
      rx_overrun    <= (fin && rx_valid && !rx_ack) || (rx_overrun && !ack);
      rx_frame_err  <= (fin && (ferr || !rxs)) || (rx_frame_err && !ack);
      rx_parity_err <= (fin && perr) || (rx_parity_err && !ack);
      if (!tick) tmr <= tmr - TW'(1);
      case (state)
        ST_IDLE: if (rxs_d && !rxs) begin
          state <= ST_START;
          tmr   <= TW'(HALF - 1);
        end
        ST_START: if (tick) begin
          state <= rxs ? ST_IDLE : ST_DATA;
          tmr   <= TW'(DIV - 1);
          bcnt  <= '0;
          perr  <= 1'b0;
          ferr  <= 1'b0;
        end
        ST_DATA: if (tick) begin
          shreg <= {rxs, shreg[WIDTH-1:1]};
          tmr   <= TW'(DIV - 1);
          bcnt  <= bcnt == CW'(WIDTH - 1) ? '0 : bcnt + CW'(1);
          if (bcnt == CW'(WIDTH - 1)) state <= PARITY == PAR_NONE ? ST_STOP : ST_PARITY;
        end
        ST_PARITY: if (tick) begin
          perr  <= (^shreg ^ rxs) != (PARITY == PAR_ODD);
          tmr   <= TW'(DIV - 1);
          state <= ST_STOP;
        end
        ST_STOP: if (tick) begin
          ferr  <= ferr || !rxs;
          tmr   <= TW'(DIV - 1);
          bcnt  <= bcnt + CW'(1);
          if (fin) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: 8N1, 8E1 and 8N2 receivers driven in parallel and checked against a frame-level model
module tb_uart_rx_cfg;
  import uart_pkg::*;
  localparam int DIV = 50000000 / 115200;
  logic       clk = 1'b0;
  logic       rst_l [3];
  logic       rx_l [3];
  logic       ack_l [3];
  logic [7:0] data_l [3];
  logic       valid_l [3];
  logic       idle_l [3];
  logic       fe_l [3];
  logic       pe_l [3];
  logic       ov_l [3];
  int         total = 0;
  int         passed = 0;
  always #10 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_rx_cfg #(
      .PARITY   (g == 1 ? PAR_EVEN : PAR_NONE),
      .STOP_BITS(g == 2 ? 2 : 1)
    ) u_dut (
      .clk50m       (clk),
      .rst_n        (rst_l[g]),
      .rx           (rx_l[g]),
      .rx_ack       (ack_l[g]),
      .rx_data      (data_l[g]),
      .rx_valid     (valid_l[g]),
      .rx_idle      (idle_l[g]),
      .rx_frame_err (fe_l[g]),
      .rx_parity_err(pe_l[g]),
      .rx_overrun   (ov_l[g])
    );
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  // frame bits LSB first: start, 8 data, [parity], stop(s); p = parity bit sent, s = last stop bit sent
  function automatic logic [11:0] mk(input int k, input logic [7:0] d, input logic p, input logic s);
    return k == 0 ? {2'b11, s, d, 1'b0} : k == 1 ? {1'b1, s, p, d, 1'b0} : {1'b1, s, 1'b1, d, 1'b0};
  endfunction
  // reference model: decode a sent frame into {frame_err, parity_err, data}
  function automatic logic [9:0] model(input int k, input logic [11:0] f);
    logic [7:0] d;
    logic       pe, fe;
    int         s;
    d  = f[8:1];
    s  = k == 1 ? 10 : 9;
    pe = k == 1 && ((^d) != f[9]);
    fe = !f[s] || (k == 2 && !f[s+1]);
    return {fe, pe, d};
  endfunction
  task automatic send(input int k, input logic [11:0] f);
    for (int i = 0; i < (k == 0 ? 10 : 11); i++) begin
      rx_l[k] = f[i];
      repeat (DIV) @(negedge clk);
    end
    rx_l[k] = 1'b1;
  endtask
  task automatic chk_idle(input int k, input string tag);
    chk($sformatf("k%0d %s idle", k, tag), 8'(idle_l[k]), 8'd1);
    chk($sformatf("k%0d %s valid", k, tag), 8'(valid_l[k]), 8'd0);
    chk($sformatf("k%0d %s flags", k, tag), {5'd0, fe_l[k], pe_l[k], ov_l[k]}, 8'd0);
  endtask
  task automatic check_frame(input int k, input logic [9:0] e, input logic ov);
    int n = 0;
    while (!valid_l[k] && n < 2 * DIV) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("k%0d valid", k), 8'(valid_l[k]), 8'd1);
    chk($sformatf("k%0d data", k), data_l[k], e[7:0]);
    chk($sformatf("k%0d flags", k), {5'd0, fe_l[k], pe_l[k], ov_l[k]}, {5'd0, e[9], e[8], ov});
    ack_l[k] = 1'b1;
    @(negedge clk);
    ack_l[k] = 1'b0;
    chk($sformatf("k%0d valid after ack", k), 8'(valid_l[k]), 8'd0);
    chk($sformatf("k%0d flags after ack", k), {5'd0, fe_l[k], pe_l[k], ov_l[k]}, 8'd0);
  endtask
  task automatic rand_frames(input int k, input int n);
    logic [7:0]  d;
    logic [11:0] f;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      f = mk(k, d, (^d) ^ ($urandom_range(0, 3) == 0), $urandom_range(0, 4) != 0);
      send(k, f);
      check_frame(k, model(k, f), 1'b0);
    end
  endtask
  task automatic run0;
    logic [11:0] f;
    f = mk(0, 8'hA5, 1'b0, 1'b1);
    send(0, f);
    check_frame(0, model(0, f), 1'b0);
    send(0, mk(0, 8'h11, 1'b0, 1'b1));
    f = mk(0, 8'h22, 1'b0, 1'b1);
    send(0, f);
    check_frame(0, model(0, f), 1'b1);
    rx_l[0] = 1'b0;
    repeat (100) @(negedge clk);
    rx_l[0] = 1'b1;
    repeat (DIV) @(negedge clk);
    chk_idle(0, "glitch");
    f = mk(0, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rx_l[0] = f[i];
      repeat (DIV) @(negedge clk);
    end
    rx_l[0] = f[4];
    repeat (DIV / 2) @(negedge clk);
    rst_l[0] = 1'b0;
    #1;
    chk_idle(0, "mid-frame reset");
    chk("k0 reset data", data_l[0], 8'h00);
    rx_l[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst_l[0] = 1'b1;
    repeat (DIV) @(negedge clk);
    chk_idle(0, "after reset");
    f = mk(0, 8'h7E, 1'b0, 1'b1);
    send(0, f);
    check_frame(0, model(0, f), 1'b0);
    rand_frames(0, 2);
  endtask
  task automatic run1;
    logic [11:0] f;
    f = mk(1, 8'h03, 1'b1, 1'b1);
    send(1, f);
    check_frame(1, model(1, f), 1'b0);
    f = mk(1, 8'h03, 1'b0, 1'b1);
    send(1, f);
    check_frame(1, model(1, f), 1'b0);
    rand_frames(1, 3);
  endtask
  task automatic run2;
    logic [11:0] f;
    f = mk(2, 8'h55, 1'b0, 1'b0);
    send(2, f);
    check_frame(2, model(2, f), 1'b0);
    rand_frames(2, 3);
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_l[k] = 1'b0;
      rx_l[k]  = 1'b1;
      ack_l[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_idle(k, "reset");
      chk($sformatf("k%0d reset data", k), data_l[k], 8'h00);
      rst_l[k] = 1'b1;
    end
    repeat (5) @(negedge clk);
    fork
      run0();
      run1();
      run2();
    join
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
